// File: rtl/vga_mem_ctrl.sv
// Write-port scheduler for the 1-bit 120x120 video memory: VBlank-deferred full clear plus plot writes.
// Optional plot buffer enabled by defining VGA_MEM_PLOT_FIFO_EN (default build: no FIFO).
module vga_mem_ctrl #(
    parameter int unsigned MEM_WIDTH_X   = 120,
    parameter int unsigned MEM_WIDTH_Y   = 120,
    parameter int unsigned MEM_ADDR_BITS = 14,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iClear,
    input  logic                     iVBlank,
    input  logic                     iValid,
    input  logic [6:0]               iXm,
    input  logic [6:0]               iYm,
    output logic                     oReady,
    output logic                     oMemWe,
    output logic [MEM_ADDR_BITS-1:0] oMemAddr,
    output logic                     oMemData,
    output logic                     oBusy,
    output logic                     oClipped
);

    typedef enum logic [1:0] {IDLE, WAIT_VB, CLEAR} stateT;

    localparam logic [MEM_ADDR_BITS-1:0] LAST_ADDR  = MEM_ADDR_BITS'(MEM_WIDTH_X * MEM_WIDTH_Y - 1);
    localparam logic [MEM_ADDR_BITS-1:0] ROW_STRIDE = MEM_ADDR_BITS'(MEM_WIDTH_X);

    if ((64'd1 << MEM_ADDR_BITS) < 64'(MEM_WIDTH_X * MEM_WIDTH_Y)) begin : gBadAddrBits
        $error("MEM_ADDR_BITS too small for MEM_WIDTH_X*MEM_WIDTH_Y");
    end
    if (FIFO_DEPTH == 0 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadFifoDepth
        $error("FIFO_DEPTH must be a power of 2");
    end

    stateT                    state, stateNext;
    logic [MEM_ADDR_BITS-1:0] clrCnt, clrCntNext;
    logic                     plotGo;
    logic [6:0]               plotX, plotY;
    logic                     plotInRange;
    logic                     readyNext;
    logic                     weNext, dataNext, clipNext;
    logic [MEM_ADDR_BITS-1:0] addrNext;

`ifdef VGA_MEM_PLOT_FIFO_EN
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [13:0]    fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   count, countNext;
    logic             push, pop, bypass, store, popAllowed;

    // An empty FIFO forwards a fresh request straight to the write stage, keeping latency at 1.
    always_comb begin
        push       = iValid && oReady;
        popAllowed = (state != CLEAR);
        pop        = popAllowed && (count != '0);
        bypass     = popAllowed && push && (count == '0);
        store      = push && !bypass;
        plotGo     = pop || bypass;
        plotX      = pop ? fifoMem[rdPtr][13:7] : iXm;
        plotY      = pop ? fifoMem[rdPtr][6:0]  : iYm;
        countNext  = count + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
        readyNext  = (countNext != (PTR_W+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge iClk) begin
        if (store) begin
            fifoMem[wrPtr] <= {iXm, iYm};
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (store) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= countNext;
        end
    end
`else
    assign plotGo    = iValid && oReady;
    assign plotX     = iXm;
    assign plotY     = iYm;
    assign readyNext = (stateNext != CLEAR);
`endif

    assign plotInRange = (32'(plotX) < MEM_WIDTH_X) && (32'(plotY) < MEM_WIDTH_Y);

    // Clear writes trail the state by one cycle, so a plot taken on the WAIT_VB->CLEAR
    // edge still gets its slot and the last clear write lands on the edge leaving CLEAR.
    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        weNext     = 1'b0;
        dataNext   = oMemData;
        addrNext   = oMemAddr;
        clipNext   = 1'b0;

        case (state)
            IDLE: begin
                if (iClear) begin
                    stateNext = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (iVBlank) begin
                    stateNext  = CLEAR;
                    clrCntNext = '0;
                end
            end
            CLEAR: begin
                if (clrCnt == LAST_ADDR) begin
                    stateNext = IDLE;
                end else begin
                    clrCntNext = clrCnt + MEM_ADDR_BITS'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        if (state == CLEAR) begin
            weNext   = 1'b1;
            dataNext = 1'b0;
            addrNext = clrCnt;
        end else if (plotGo) begin
            if (plotInRange) begin
                weNext   = 1'b1;
                dataNext = 1'b1;
                addrNext = ROW_STRIDE * MEM_ADDR_BITS'(plotY) + MEM_ADDR_BITS'(plotX);
            end else begin
                clipNext = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= IDLE;
            clrCnt   <= '0;
            oMemWe   <= 1'b0;
            oMemAddr <= '0;
            oMemData <= 1'b0;
            oBusy    <= 1'b0;
            oClipped <= 1'b0;
            oReady   <= 1'b1;
        end else begin
            state    <= stateNext;
            clrCnt   <= clrCntNext;
            oMemWe   <= weNext;
            oMemAddr <= addrNext;
            oMemData <= dataNext;
            oBusy    <= (stateNext != IDLE);
            oClipped <= clipNext;
            oReady   <= readyNext;
        end
    end

endmodule

// File: tb/tb_vga_mem_ctrl.sv
// Self-checking bench for vga_mem_ctrl: random plots against an arithmetic address model,
// clear scheduling, clipping, arbitration during clear, async reset and ignored re-clears.
module tb_vga_mem_ctrl;

    logic        iClk = 1'b0;
    logic        iRst_n, iClear, iVBlank, iValid;
    logic [6:0]  iXm, iYm;
    logic        oReady, oMemWe, oMemData, oBusy, oClipped;
    logic [13:0] oMemAddr;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    vga_mem_ctrl dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iClear  (iClear),
        .iVBlank (iVBlank),
        .iValid  (iValid),
        .iXm     (iXm),
        .iYm     (iYm),
        .oReady  (oReady),
        .oMemWe  (oMemWe),
        .oMemAddr(oMemAddr),
        .oMemData(oMemData),
        .oBusy   (oBusy),
        .oClipped(oClipped)
    );

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic int refAddr(int x, int y);
        return 120 * y + x;
    endfunction

    function automatic bit refClip(int x, int y);
        return (x >= 120) || (y >= 120);
    endfunction

    task automatic test_reset();
        iRst_n = 1'b0; iClear = 1'b0; iVBlank = 1'b0; iValid = 1'b0; iXm = '0; iYm = '0;
        repeat (3) tick();
        checks++; if (oMemWe !== 1'b0)    begin errors++; $display("FAIL reset_we got %b want 0", oMemWe); end
        checks++; if (oMemAddr !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", oMemAddr); end
        checks++; if (oMemData !== 1'b0)  begin errors++; $display("FAIL reset_data got %b want 0", oMemData); end
        checks++; if (oBusy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", oBusy); end
        checks++; if (oClipped !== 1'b0)  begin errors++; $display("FAIL reset_clip got %b want 0", oClipped); end
        checks++; if (oReady !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b want 1", oReady); end
        #3 iRst_n = 1'b1;
        tick();
        checks++; if (oReady !== 1'b1 || oMemWe !== 1'b0) begin
            errors++; $display("FAIL post_reset got ready=%b we=%b want ready=1 we=0", oReady, oMemWe);
        end
    endtask

    task automatic test_plot();
        int x, y;
        iValid = 1'b1; iXm = 7'd5; iYm = 7'd2;
        tick();
        iValid = 1'b0;
        checks++; if (oMemWe !== 1'b1 || oMemAddr !== 14'd245 || oMemData !== 1'b1) begin
            errors++; $display("FAIL plot_5_2 got we=%b addr=%0d data=%b want we=1 addr=245 data=1", oMemWe, oMemAddr, oMemData);
        end
        // back-to-back random requests, iValid held high
        for (int i = 0; i < 24; i++) begin
            x = (i % 3 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 119));
            y = (i % 3 == 1) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 119));
            iValid = 1'b1; iXm = 7'(x); iYm = 7'(y);
            tick();
            checks++;
            if (refClip(x, y)) begin
                if (oMemWe !== 1'b0 || oClipped !== 1'b1) begin
                    errors++; $display("FAIL plot_rand_clip x=%0d y=%0d got we=%b clip=%b want we=0 clip=1", x, y, oMemWe, oClipped);
                end
            end else if (oMemWe !== 1'b1 || oMemData !== 1'b1 || oClipped !== 1'b0 || oMemAddr !== 14'(refAddr(x, y))) begin
                errors++; $display("FAIL plot_rand x=%0d y=%0d got we=%b data=%b clip=%b addr=%0d want we=1 data=1 clip=0 addr=%0d",
                                   x, y, oMemWe, oMemData, oClipped, oMemAddr, refAddr(x, y));
            end
        end
        iValid = 1'b0;
        tick();
        checks++; if (oMemWe !== 1'b0 || oClipped !== 1'b0) begin
            errors++; $display("FAIL plot_idle got we=%b clip=%b want 0 0", oMemWe, oClipped);
        end
    endtask

    task automatic test_clear();
        int seen = 0, badBusy = 0, writes = 0, badSeq = 0, cyc = 0, x, y;
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        repeat (50) begin
            tick();
            if (oMemWe !== 1'b0) seen++;
            if (oBusy !== 1'b1) badBusy++;
        end
        checks++; if (seen != 0)    begin errors++; $display("FAIL clear_wait_writes got %0d want 0", seen); end
        checks++; if (badBusy != 0) begin errors++; $display("FAIL clear_wait_busy low_cycles got %0d want 0", badBusy); end
        iVBlank = 1'b1;
        badBusy = 0;
        while (writes < 14400 && cyc < 20000) begin
            tick();
            cyc++;
            if (oMemWe === 1'b1) begin
                if (oMemData !== 1'b0 || oMemAddr !== 14'(writes)) badSeq++;
                writes++;
                if (writes < 14400 && oBusy !== 1'b1) badBusy++;
                if (writes == 100) iVBlank = 1'b0;
            end else if (writes > 0) begin
                badSeq++;
            end
        end
        checks++; if (writes != 14400) begin errors++; $display("FAIL clear_count got %0d want 14400", writes); end
        checks++; if (badSeq != 0)     begin errors++; $display("FAIL clear_sequence bad_cycles got %0d want 0", badSeq); end
        checks++; if (badBusy != 0)    begin errors++; $display("FAIL clear_busy low_during_clear got %0d want 0", badBusy); end
        tick();
        checks++; if (oMemWe !== 1'b0 || oBusy !== 1'b0 || oReady !== 1'b1) begin
            errors++; $display("FAIL clear_done got we=%b busy=%b ready=%b want 0 0 1", oMemWe, oBusy, oReady);
        end
        x = int'($urandom_range(0, 119)); y = int'($urandom_range(0, 119));
        iValid = 1'b1; iXm = 7'(x); iYm = 7'(y);
        tick();
        iValid = 1'b0;
        checks++; if (oMemWe !== 1'b1 || oMemData !== 1'b1 || oMemAddr !== 14'(refAddr(x, y))) begin
            errors++; $display("FAIL clear_then_plot got we=%b data=%b addr=%0d want 1 1 %0d", oMemWe, oMemData, oMemAddr, refAddr(x, y));
        end
    endtask

    task automatic test_clip();
        iValid = 1'b1; iXm = 7'd120; iYm = 7'd0;
        tick();
        checks++; if (oClipped !== 1'b1 || oMemWe !== 1'b0) begin
            errors++; $display("FAIL clip_120_0 got clip=%b we=%b want 1 0", oClipped, oMemWe);
        end
        iXm = 7'd3; iYm = 7'd119;
        tick();
        iValid = 1'b0;
        checks++; if (oClipped !== 1'b0 || oMemWe !== 1'b1 || oMemAddr !== 14'd14283) begin
            errors++; $display("FAIL plot_3_119 got clip=%b we=%b addr=%0d want 0 1 14283", oClipped, oMemWe, oMemAddr);
        end
        tick();
        checks++; if (oClipped !== 1'b0) begin errors++; $display("FAIL clip_pulse got %b want 0", oClipped); end
    endtask

    task automatic test_clear_ready();
        int px[5], py[5];
        int expQ[$];
        int idx = 0, clr = 0, cyc = 0, badPlot = 0, badReady = 0, acceptedInClear = -1;
        bit vBefore, rBefore;
        for (int i = 0; i < 5; i++) begin
            px[i] = int'($urandom_range(0, 119));
            py[i] = int'($urandom_range(0, 119));
        end
        iClear = 1'b1; iVBlank = 1'b1;
        tick();
        iClear = 1'b0;
        while (oMemWe !== 1'b1 && cyc < 10) begin tick(); cyc++; end
        clr = (oMemWe === 1'b1 && oMemData === 1'b0) ? 1 : 0;
        iVBlank = 1'b0;
        cyc = 0;
        while ((idx < 5 || expQ.size() > 0 || clr < 14400) && cyc < 20000) begin
            iValid = (idx < 5);
            if (idx < 5) begin iXm = 7'(px[idx]); iYm = 7'(py[idx]); end
            vBefore = iValid;
            rBefore = oReady;
`ifndef VGA_MEM_PLOT_FIFO_EN
            if (clr >= 1 && clr <= 14399 && oReady !== 1'b0) badReady++;
`endif
            tick();
            cyc++;
            if (vBefore && rBefore) begin
                expQ.push_back(refAddr(px[idx], py[idx]));
                idx++;
            end
            if (oMemWe === 1'b1 && oMemData === 1'b0) begin
                clr++;
            end else if (oMemWe === 1'b1 && oMemData === 1'b1) begin
                if (clr < 14400) badPlot++;
                if (expQ.size() == 0 || oMemAddr !== 14'(expQ[0])) badPlot++;
                else void'(expQ.pop_front());
            end
            if (clr == 14000) acceptedInClear = idx;
        end
        iValid = 1'b0;
        checks++; if (idx != 5 || expQ.size() != 0 || clr != 14400) begin
            errors++; $display("FAIL ready_clear_complete got accepted=%0d pending=%0d clears=%0d want 5 0 14400", idx, expQ.size(), clr);
        end
        checks++; if (badPlot != 0) begin errors++; $display("FAIL ready_clear_plot_order bad got %0d want 0", badPlot); end
`ifdef VGA_MEM_PLOT_FIFO_EN
        checks++; if (acceptedInClear != 4) begin errors++; $display("FAIL fifo_accept_in_clear got %0d want 4", acceptedInClear); end
`else
        checks++; if (acceptedInClear != 0) begin errors++; $display("FAIL accept_in_clear got %0d want 0", acceptedInClear); end
        checks++; if (badReady != 0) begin errors++; $display("FAIL ready_during_clear high_cycles got %0d want 0", badReady); end
`endif
        tick();
    endtask

    task automatic test_reset_midclear();
        int cyc = 0, writes = 0, notIdle = 0;
        iClear = 1'b1; iVBlank = 1'b1;
        tick();
        iClear = 1'b0;
        while (!(oMemWe === 1'b1 && oMemAddr === 14'd7000) && cyc < 10000) begin tick(); cyc++; end
        checks++; if (cyc >= 10000) begin errors++; $display("FAIL midclear_reach got timeout want addr 7000"); end
        #2 iRst_n = 1'b0;
        #1;
        checks++; if (oMemWe !== 1'b0 || oMemAddr !== 14'd0 || oMemData !== 1'b0 || oBusy !== 1'b0 || oClipped !== 1'b0 || oReady !== 1'b1) begin
            errors++; $display("FAIL async_reset got we=%b addr=%0d data=%b busy=%b clip=%b ready=%b want 0 0 0 0 0 1",
                               oMemWe, oMemAddr, oMemData, oBusy, oClipped, oReady);
        end
        #2 iRst_n = 1'b1;
        iVBlank = 1'b0;
        repeat (20) begin
            tick();
            if (oMemWe !== 1'b0) writes++;
            if (oBusy !== 1'b0 || oReady !== 1'b1) notIdle++;
        end
        checks++; if (writes != 0 || notIdle != 0) begin
            errors++; $display("FAIL after_reset_idle got writes=%0d not_idle=%0d want 0 0", writes, notIdle);
        end
    endtask

    task automatic test_clear_plus_plot();
        int writes = 0, extra = 0;
        iVBlank = 1'b0; iClear = 1'b1; iValid = 1'b1; iXm = 7'd0; iYm = 7'd0;
        tick();
        iClear = 1'b0; iValid = 1'b0;
        checks++; if (oMemWe !== 1'b1 || oMemData !== 1'b1 || oMemAddr !== 14'd0 || oBusy !== 1'b1) begin
            errors++; $display("FAIL clear_plus_plot got we=%b data=%b addr=%0d busy=%b want 1 1 0 1", oMemWe, oMemData, oMemAddr, oBusy);
        end
        tick();
        checks++; if (oMemWe !== 1'b0 || oBusy !== 1'b1) begin
            errors++; $display("FAIL wait_vb_after_combo got we=%b busy=%b want 0 1", oMemWe, oBusy);
        end
        iVBlank = 1'b1;
        for (int c = 0; c < 14600; c++) begin
            if (iClear) iClear = 1'b0;
            tick();
            if (oMemWe === 1'b1 && oMemData === 1'b0) begin
                writes++;
                if (writes == 5000) iClear = 1'b1;
            end else if (oMemWe === 1'b1) begin
                extra++;
            end
        end
        iVBlank = 1'b0;
        checks++; if (writes != 14400 || extra != 0) begin
            errors++; $display("FAIL reclear_ignored got clears=%0d plots=%0d want 14400 0", writes, extra);
        end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reclear_busy got %b want 0", oBusy); end
    endtask

    initial begin
        test_reset();
        test_plot();
        test_clear();
        test_clip();
        test_clear_ready();
        test_reset_midclear();
        test_clear_plus_plot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

endmodule
